// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame-animation controller for the charlieplexed LED matrix.
//
// Holds NFRAMES x 56-bit frames and plays a captured range [first..last] (wrapping
// through NFRAMES-1 to 0 when first > last) at one frame per max(hold,1) clk cycles.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (frame store is not cleared)
//   wr_en        frame-store write strobe
//   wr_addr      frame index to write
//   wr_data      frame bits, row r in bits [7r+6:7r]
//   start        pulse: (re)start playback of the range
//   stop         pulse: abort playback, wins over start
//   loop         level: repeat the range indefinitely
//   first, last  range bounds, captured on start
//   hold         cycles per frame, captured on start (0 acts as 1)
//   pattern      registered frame to ledmatrix (0 while idle)
//   frame_idx    index of the frame on pattern
//   frame_strobe one-cycle pulse when a new frame is loaded
//   busy         high while playing
//   done         high once a non-looping range has finished
module pattern_sequencer #(
  parameter int unsigned NFRAMES = 8,
  parameter int unsigned AW      = $clog2(NFRAMES),
  parameter int unsigned HOLD_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [55:0]       wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [AW-1:0]     first,
  input  logic [AW-1:0]     last,
  input  logic [HOLD_W-1:0] hold,
  output logic [55:0]       pattern,
  output logic [AW-1:0]     frame_idx,
  output logic              frame_strobe,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [55:0]       pattern_q, pattern_d;
  logic              strobe_q, strobe_d;

  // Operands captured when start is accepted.
  logic [AW-1:0]     first_q, first_d;
  logic [AW-1:0]     last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              loop_q, loop_d;

  logic [55:0]       mem_q [NFRAMES];

  // Frame store: writable in any state, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    first_d  = first_q;
    last_d   = last_q;
    hold_d   = hold_q;
    loop_d   = loop_q;

    if (stop) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (start) begin
      state_d  = StPlay;
      idx_d    = first;
      cnt_d    = '0;
      strobe_d = 1'b1;
      first_d  = first;
      last_d   = last;
      hold_d   = (hold == '0) ? HOLD_W'(1) : hold;
      loop_d   = loop;
    end else if (state_q == StPlay) begin
      if (cnt_q == hold_q - HOLD_W'(1)) begin
        cnt_d = '0;
        if (idx_q != last_q) begin
          // NFRAMES is a power of two, so AW-bit overflow gives the wrap to 0.
          idx_d    = idx_q + AW'(1);
          strobe_d = 1'b1;
        end else if (loop_q) begin
          idx_d    = first_q;
          strobe_d = 1'b1;
        end else begin
          state_d = StDone;
        end
      end else begin
        cnt_d = cnt_q + HOLD_W'(1);
      end
    end

    // Reload the shown frame every cycle so writes to it appear next cycle;
    // a write landing on the same index this cycle is forwarded.
    if (state_d == StIdle) begin
      pattern_d = '0;
    end else if (wr_en && (wr_addr == idx_d)) begin
      pattern_d = wr_data;
    end else begin
      pattern_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      pattern_q <= '0;
      strobe_q  <= 1'b0;
      first_q   <= '0;
      last_q    <= '0;
      hold_q    <= '0;
      loop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      strobe_q  <= strobe_d;
      first_q   <= first_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      loop_q    <= loop_d;
    end
  end

  assign pattern      = pattern_q;
  assign frame_idx    = idx_q;
  assign frame_strobe = strobe_q;
  assign busy         = (state_q == StPlay);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [55:0] wr_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [2:0]  first = '0;
  logic [2:0]  last = '0;
  logic [15:0] hold = '0;
  logic [55:0] pattern;
  logic [2:0]  frame_idx;
  logic        frame_strobe;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Bench-side copy of the frame store.
  logic [55:0] frm [8];

  typedef struct {
    logic        start;
    logic        stop;
    logic [2:0]  first;
    logic [2:0]  last;
    logic [15:0] hold;
    logic        lp;
    logic [55:0] pat;
    logic [2:0]  idx;
    logic        strb;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t tbl [16];

  pattern_sequencer #(
    .NFRAMES(8),
    .AW     (3),
    .HOLD_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .first       (first),
    .last        (last),
    .hold        (hold),
    .pattern     (pattern),
    .frame_idx   (frame_idx),
    .frame_strobe(frame_strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [55:0] got, input logic [55:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [55:0] p, input logic [2:0] idx,
                            input logic st, input logic b, input logic d);
    chk({tag, ".pattern"}, pattern, p);
    chk({tag, ".frame_idx"}, 56'(frame_idx), 56'(idx));
    chk({tag, ".frame_strobe"}, 56'(frame_strobe), 56'(st));
    chk({tag, ".busy"}, 56'(busy), 56'(b));
    chk({tag, ".done"}, 56'(done), 56'(d));
  endtask

  task automatic write_frame(input logic [2:0] a, input logic [55:0] v);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = v;
    frm[a]  = v;
    cyc();
    wr_en   = 1'b0;
  endtask

  initial begin
    // Table: first=0 last=3 hold=3 loop=0; operand inputs change after start
    // to confirm they were captured.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 3; k++) begin
        int n;
        n = f * 3 + k;
        tbl[n] = '{start: (n == 0), stop: 1'b0,
                   first: (n == 0) ? 3'd0 : 3'd5, last: (n == 0) ? 3'd3 : 3'd5,
                   hold: (n == 0) ? 16'd3 : 16'd1, lp: (n != 0),
                   pat: 56'h1 << f, idx: 3'(f), strb: (k == 0), bsy: 1'b1, dn: 1'b0};
      end
    end
    tbl[12] = '{start: 1'b0, stop: 1'b0, first: 3'd5, last: 3'd5, hold: 16'd1, lp: 1'b1,
                pat: 56'h8, idx: 3'd3, strb: 1'b0, bsy: 1'b0, dn: 1'b1};
    tbl[13] = tbl[12];
    tbl[14] = '{start: 1'b0, stop: 1'b1, first: 3'd5, last: 3'd5, hold: 16'd1, lp: 1'b1,
                pat: 56'h0, idx: 3'd3, strb: 1'b0, bsy: 1'b0, dn: 1'b0};
    tbl[15] = tbl[14];
    tbl[15].stop = 1'b0;

    // Reset values.
    rst = 1'b1;
    cyc();
    expect_out("reset", 56'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    write_frame(3'd0, 56'h1);
    write_frame(3'd1, 56'h2);
    write_frame(3'd2, 56'h4);
    write_frame(3'd3, 56'h8);
    write_frame(3'd5, 56'h50);
    write_frame(3'd6, 56'h60);
    write_frame(3'd7, 56'h70);
    cyc();
    expect_out("idle_after_writes", 56'h0, 3'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start;
      stop  = tbl[i].stop;
      first = tbl[i].first;
      last  = tbl[i].last;
      hold  = tbl[i].hold;
      loop  = tbl[i].lp;
      cyc();
      expect_out($sformatf("tbl%0d", i), tbl[i].pat, tbl[i].idx, tbl[i].strb, tbl[i].bsy,
                 tbl[i].dn);
    end
    start = 1'b0;
    stop  = 1'b0;

    // Looping, hold=2, then stop mid-frame.
    first = 3'd0; last = 3'd3; hold = 16'd2; loop = 1'b1; start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cyc();
      start = 1'b0;
      expect_out($sformatf("loop%0d", i), frm[(i / 2) % 4], 3'((i / 2) % 4), (i % 2 == 0),
                 1'b1, 1'b0);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    expect_out("loop_stop", 56'h0, 3'd1, 1'b0, 1'b0, 1'b0);

    // Wrapped range 6..1, hold=1.
    first = 3'd6; last = 3'd1; hold = 16'd1; loop = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] e;
      e = 3'(6 + i);
      cyc();
      start = 1'b0;
      expect_out($sformatf("wrap%0d", i), frm[e], e, 1'b1, 1'b1, 1'b0);
    end
    cyc();
    expect_out("wrap_done", frm[1], 3'd1, 1'b0, 1'b0, 1'b1);

    // hold=0 on a single looping frame, then simultaneous start+stop.
    first = 3'd5; last = 3'd5; hold = 16'd0; loop = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      start = 1'b0;
      expect_out($sformatf("hold0_%0d", i), 56'h50, 3'd5, 1'b1, 1'b1, 1'b0);
    end
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    expect_out("start_stop", 56'h0, 3'd5, 1'b0, 1'b0, 1'b0);

    // Write bypass on the shown frame, and a write to the next frame.
    first = 3'd0; last = 3'd3; hold = 16'd4; loop = 1'b0; start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      start = 1'b0;
      expect_out($sformatf("byp%0d", i), frm[i / 4], 3'(i / 4), (i % 4 == 0), 1'b1, 1'b0);
      if (i == 9) begin
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 56'hFF; frm[2] = 56'hFF;
      end else if (i == 10) begin
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 56'h88; frm[3] = 56'h88;
      end else begin
        wr_en = 1'b0;
      end
    end

    // Reset mid-play, then replay the stored frames.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_out("rst_mid", 56'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    hold = 16'd1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      start = 1'b0;
      expect_out($sformatf("replay%0d", i), frm[i], 3'(i), 1'b1, 1'b1, 1'b0);
    end
    chk("replay_frame2", frm[2], 56'hFF);
    cyc();
    expect_out("replay_done", 56'h88, 3'd3, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
